// File: rtl/output_ram_writer_pkg.sv
// Shared definitions for the output RAM write controller: state encoding and
// the index-counter width helper, also used by the top-level controller.
package output_ram_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    // The counter must be able to hold r itself once the last word is accepted.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/output_ram_writer.sv
// Clears every output_ram entry, then writes r handshaked result words to
// consecutive indices and flags completion for the top-level controller.
module output_ram_writer
    import output_ram_writer_pkg::*;
#(
    parameter int r = 8,
    parameter int n = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [n-1:0]         in_data,
    output logic                 in_ready,
    output logic                 ram_clr,
    output logic                 ram_wr,
    output logic [$clog2(r)-1:0] ram_i,
    output logic [n-1:0]         ram_pi,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(r);
    localparam int IW = $clog2(r);
    localparam logic [CW-1:0] LAST  = CW'(r - 1);
    localparam logic [CW-1:0] DEPTH = CW'(r);

    wr_state_t     state, state_next;
    logic [CW-1:0] count, count_next;
    logic          accept;

    logic          clr_d, wr_d, busy_d, done_d;
    logic [IW-1:0] i_d;
    logic [n-1:0]  pi_d;

    // in_ready depends only on state and count so upstream never sees a loop.
    assign in_ready = (state == RUN) && (count < DEPTH);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            CLEAR: begin
                if (count == LAST) begin
                    state_next = RUN;
                    count_next = '0;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            RUN: begin
                if (accept) begin
                    count_next = count + CW'(1);
                    if (count == LAST) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so the registered copies
    // line up with the state they describe, e.g. last write and done together.
    always_comb begin
        clr_d  = (state_next == CLEAR);
        wr_d   = accept;
        busy_d = (state_next == CLEAR) || (state_next == RUN);
        done_d = (state_next == DONE);
        i_d    = ram_i;
        pi_d   = ram_pi;
        if (state_next == CLEAR) i_d = count_next[IW-1:0];
        if (accept) begin
            i_d  = count[IW-1:0];
            pi_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_clr <= 1'b0;
            ram_wr  <= 1'b0;
            ram_i   <= '0;
            ram_pi  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            ram_clr <= clr_d;
            ram_wr  <= wr_d;
            ram_i   <= i_d;
            ram_pi  <= pi_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
